regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the 4x8 two-read/one-write register file. Adds configurable depth and width, a second write port with fixed priority, and optional read-during-write bypass.
- Adds an optional hard-wired zero register and a multi-cycle clear sequencer with a busy flag.
- Sits between the datapath/ALU and the control unit. The flattened register dump bus feeds the debug/display logic.

Parameters:
- NUM_REGS, 4, number of registers; must be a power of two and at least 2.
- DATA_W, 8, register width in bits.
- ADDR_W, $clog2(NUM_REGS), address width; derived, never overridden.
- BYPASS, 0, 1 = read ports return same-cycle write data on an address match.
- ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_data1  out  DATA_W  read port 1 data; combinational.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data2  out  DATA_W  read port 2 data; combinational.
- wr_en_a  in  1  write enable, port A.
- wr_addr_a  in  ADDR_W  write address, port A.
- wr_data_a  in  DATA_W  write data, port A.
- wr_en_b  in  1  write enable, port B; higher priority than port A.
- wr_addr_b  in  ADDR_W  write address, port B.
- wr_data_b  in  DATA_W  write data, port B.
- clear_req  in  1  single-cycle pulse; starts the sequential clear of all registers.
- busy  out  1  high while the clear is in progress.
- reg_flat  out  NUM_REGS*DATA_W  all registers; reg i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (asynchronous, active-high):
  - All registers go to 0 immediately; reg_flat = 0.
  - Clear FSM goes to IDLE, clear counter = 0, busy = 0.
  - Reset asserted mid-clear aborts the clear; all registers are 0 regardless.
- Writes:
  - Take effect at the rising clk edge and are visible on reads and reg_flat after that edge.
  - Data changing while clk is low or high without an edge does not write.
- Dual write:
  - Port A and port B to different addresses: both commit in the same cycle.
  - Same address: port B data wins; port A is dropped.
- Reads:
  - Purely combinational from register contents and addresses.
  - rd_addr1 == rd_addr2 is legal and returns identical data on both ports.
- BYPASS=1:
  - A read address matching an enabled write address in the same cycle returns that write data before the edge.
  - B takes priority over A.
  - No bypass while busy.
- BYPASS=0: reads return pre-edge contents.
- ZERO_R0=1:
  - Writes to address 0 are discarded.
  - rd_data and reg_flat slice 0 are always 0.
  - Register 0 is never bypassed.
- Clear FSM:
  - States IDLE and CLEARING.
  - IDLE: clear_req=1 -> CLEARING, counter = 0, busy = 1 from the next cycle.
  - CLEARING: each cycle, reg[counter] <= 0 and counter increments. When counter == NUM_REGS-1, that register is cleared and the FSM returns to IDLE, so busy drops after exactly NUM_REGS cycles.
  - CLEARING: both write ports are ignored, and clear_req is ignored (no restart).
  - Reads during CLEARING return current contents, so already-cleared registers read 0.
  - clear_req and writes in the same IDLE cycle: the writes commit on that edge, then clearing starts and overwrites them.
- Widths: the counter is ADDR_W bits; wrap from NUM_REGS-1 is never used because the exit happens first. No arithmetic is performed on data.

Decomposition:
- Package regfile_pkg holds:
  - Clear-state typedef (IDLE, CLEARING).
  - Default NUM_REGS and DATA_W constants.
- One sub-module, regfile_clear_seq, owns the FSM and counter.
  - Inputs: clk, rst, clear_req.
  - Outputs: busy, clr_en, clr_addr.
- Storage, write arbitration and bypass logic stay in regfile_mp.

Test Plan:
- Defaults: rst pulse mid-cycle -> all reg_flat = 0 immediately, busy=0. Then wr_en_a=1, wr_addr_a=0, wr_data_a=8'hA1 at an edge -> rd_data1 (addr 0) = A1 after that edge, not before.
- Dual write: A writes 55 to reg1 while B writes E4 to reg2 -> both commit in one edge. Then A writes 11 and B writes 22 to reg3 -> reg3 = 22.
- wr_en_a=wr_en_b=0, toggle wr_data to 2D and sweep addresses for 3 edges -> contents unchanged. Reads on both ports track rd_addr changes combinationally.
- Regs = 01,02,03,04; clear_req for one cycle; wr_en_a=1 writing FF to reg3 during CLEARING -> busy high for exactly 4 cycles; regs zero in order 0,1,2,3; reg3 ends 0; second clear_req mid-clear has no effect.
- BYPASS=1, ZERO_R0=1, NUM_REGS=8, DATA_W=16:
  - Write 16'hBEEF to reg5 with rd_addr1=5 -> rd_data1 = BEEF in the same cycle.
  - Write 16'h1234 to reg0 -> reads 0.
- Assert rst during CLEARING with regs = AA -> busy=0 and all regs 0 immediately. After release, a normal write to reg2 succeeds on the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared types and default sizing for the multi-port register file.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

  typedef enum logic [0:0] {
    CLR_IDLE     = 1'b0,
    CLR_CLEARING = 1'b1
  } clr_state_e;

  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_DATA_W   = 8;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : regfile_clear_seq
// Brief   : Walks every register address once, one per cycle, to zero the file.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_en   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLR_IDLE: begin
        if (clear_req) begin
          state_d = CLR_CLEARING;
          cnt_d   = '0;
        end
      end
      CLR_CLEARING: begin
        busy   = 1'b1;
        clr_en = 1'b1;
        // Exit on the last address so the counter never wraps.
        if (cnt_q == LAST_ADDR) begin
          state_d = CLR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = CLR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : regfile_clear_seq
`default_nettype wire

// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Brief   : Parametrised 2-read / 2-write register file with optional bypass,
//           hard-wired zero register and sequential clear.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  bit BYPASS   = 1'b0,
  parameter  bit ZERO_R0  = 1'b0,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          rd_addr1,
  output logic [DATA_W-1:0]          rd_data1,
  input  logic [ADDR_W-1:0]          rd_addr2,
  output logic [DATA_W-1:0]          rd_data2,
  input  logic                       wr_en_a,
  input  logic [ADDR_W-1:0]          wr_addr_a,
  input  logic [DATA_W-1:0]          wr_data_a,
  input  logic                       wr_en_b,
  input  logic [ADDR_W-1:0]          wr_addr_b,
  input  logic [DATA_W-1:0]          wr_data_b,
  input  logic                       clear_req,
  output logic                       busy,
  output logic [NUM_REGS*DATA_W-1:0] reg_flat
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  logic [1:0][ADDR_W-1:0] rd_addr_all;
  logic [1:0][DATA_W-1:0] rd_data_all;

  regfile_clear_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr)
  );

  // Port B is applied after port A so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (clr_en) begin
      regs_d[clr_addr] = '0;
    end else begin
      if (wr_en_a) regs_d[wr_addr_a] = wr_data_a;
      if (wr_en_b) regs_d[wr_addr_b] = wr_data_b;
    end
    if (ZERO_R0) regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_addr_all = {rd_addr2, rd_addr1};
  assign rd_data1    = rd_data_all[0];
  assign rd_data2    = rd_data_all[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] data_sel;
    always_comb begin
      data_sel = regs_q[rd_addr_all[p]];
      if (BYPASS && !busy) begin
        if (wr_en_a && (wr_addr_a == rd_addr_all[p])) data_sel = wr_data_a;
        if (wr_en_b && (wr_addr_b == rd_addr_all[p])) data_sel = wr_data_b;
      end
      if (ZERO_R0 && (rd_addr_all[p] == '0)) data_sel = '0;
    end
    assign rd_data_all[p] = data_sel;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_flat[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Self-checking bench for regfile_mp, default and 8x16 bypass/zero builds.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default build: 4 x 8
  logic [1:0]  rd_addr1, rd_addr2, wr_addr_a, wr_addr_b;
  logic [7:0]  rd_data1, rd_data2, wr_data_a, wr_data_b;
  logic        wr_en_a, wr_en_b, clear_req, busy;
  logic [31:0] reg_flat;

  // Wide build: 8 x 16, bypass, zero register
  logic [2:0]   rd_addr1_z, rd_addr2_z, wr_addr_a_z, wr_addr_b_z;
  logic [15:0]  rd_data1_z, rd_data2_z, wr_data_a_z, wr_data_b_z;
  logic         wr_en_a_z, wr_en_b_z, clear_req_z, busy_z;
  logic [127:0] reg_flat_z;

  regfile_mp u_dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clear_req(clear_req), .busy(busy), .reg_flat(reg_flat)
  );

  regfile_mp #(
    .NUM_REGS(8), .DATA_W(16), .BYPASS(1'b1), .ZERO_R0(1'b1)
  ) u_dut_z (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1_z), .rd_data1(rd_data1_z),
    .rd_addr2(rd_addr2_z), .rd_data2(rd_data2_z),
    .wr_en_a(wr_en_a_z), .wr_addr_a(wr_addr_a_z), .wr_data_a(wr_data_a_z),
    .wr_en_b(wr_en_b_z), .wr_addr_b(wr_addr_b_z), .wr_data_b(wr_data_b_z),
    .clear_req(clear_req_z), .busy(busy_z), .reg_flat(reg_flat_z)
  );

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_ent_t;
  sb_ent_t sb_q[$];

  logic [7:0] mdl [4];

  function automatic logic [31:0] mdl_flat();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] val);
    sb_ent_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    sb_ent_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL sb_underflow: got %h expected a queued entry", obs);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    {rd_addr1, rd_addr2, wr_addr_a, wr_addr_b} = '0;
    {wr_data_a, wr_data_b, wr_en_a, wr_en_b, clear_req} = '0;
    {rd_addr1_z, rd_addr2_z, wr_addr_a_z, wr_addr_b_z} = '0;
    {wr_data_a_z, wr_data_b_z, wr_en_a_z, wr_en_b_z, clear_req_z} = '0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;

    // Asynchronous reset mid-cycle, checked before any clock edge
    #3 rst = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flat", reg_flat, 0);
    check_eq("rst_flat_z", reg_flat_z[63:0], 0);
    #4 rst = 1'b0;

    // Single write: visible only after the edge
    @(negedge clk);
    wr_en_a = 1; wr_addr_a = 2'd0; wr_data_a = 8'hA1; rd_addr1 = 2'd0;
    #1 check_eq("wr_before_edge", rd_data1, 8'h00);
    mdl[0] = 8'hA1;
    sb_push("wr_a_r0", 8'hA1);
    tick();
    sb_check(rd_data1);

    // Dual write, distinct addresses
    @(negedge clk);
    wr_addr_a = 2'd1; wr_data_a = 8'h55;
    wr_en_b = 1; wr_addr_b = 2'd2; wr_data_b = 8'hE4;
    rd_addr1 = 2'd1; rd_addr2 = 2'd2;
    mdl[1] = 8'h55; mdl[2] = 8'hE4;
    sb_push("dual_r1", 8'h55);
    sb_push("dual_r2", 8'hE4);
    tick();
    sb_check(rd_data1);
    sb_check(rd_data2);

    // Dual write, same address: B wins
    @(negedge clk);
    wr_addr_a = 2'd3; wr_data_a = 8'h11;
    wr_addr_b = 2'd3; wr_data_b = 8'h22;
    rd_addr1 = 2'd3;
    mdl[3] = 8'h22;
    sb_push("same_addr_b_wins", 8'h22);
    sb_push("flat_after_dual", mdl_flat());
    tick();
    sb_check(rd_data1);
    sb_check(reg_flat);

    // Disabled writes with changing data/addresses; reads track addresses
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en_a = 0; wr_en_b = 0; wr_data_a = 8'h2D; wr_data_b = 8'h2D;
      wr_addr_a = 2'(i); wr_addr_b = 2'(3 - i);
      rd_addr1 = 2'(i); rd_addr2 = 2'(i + 1);
      #1;
      check_eq("rd1_track", rd_data1, mdl[i]);
      check_eq("rd2_track", rd_data2, mdl[(i + 1) % 4]);
      sb_push("no_write_flat", mdl_flat());
      tick();
      sb_check(reg_flat);
    end

    // Preload 01..04
    @(negedge clk);
    wr_en_a = 1; wr_addr_a = 2'd0; wr_data_a = 8'h01;
    wr_en_b = 1; wr_addr_b = 2'd1; wr_data_b = 8'h02;
    tick();
    @(negedge clk);
    wr_addr_a = 2'd2; wr_data_a = 8'h03;
    wr_addr_b = 2'd3; wr_data_b = 8'h04;
    tick();
    mdl[0] = 8'h01; mdl[1] = 8'h02; mdl[2] = 8'h03; mdl[3] = 8'h04;
    @(negedge clk);
    wr_en_a = 0; wr_en_b = 0;
    #1 check_eq("preload_flat", reg_flat, mdl_flat());

    // Clear sequence with a write and a second request during CLEARING
    clear_req = 1;
    tick();
    check_eq("busy_start", busy, 1);
    @(negedge clk);
    clear_req = 0;
    wr_en_a = 1; wr_addr_a = 2'd3; wr_data_a = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) clear_req = 1;
      if (k == 2) clear_req = 0;
      mdl[k] = 8'h00;
      sb_push("clear_step_flat", mdl_flat());
      tick();
      sb_check(reg_flat);
      check_eq("clear_step_busy", busy, (k < 3));
      @(negedge clk);
    end
    wr_en_a = 0; clear_req = 0;
    rd_addr1 = 2'd3;
    tick();
    check_eq("clear_no_restart", busy, 0);
    check_eq("clear_r3_zero", rd_data1, 8'h00);

    // Reset asserted in the middle of a clear
    @(negedge clk);
    wr_en_a = 1; wr_addr_a = 2'd0; wr_data_a = 8'hAA;
    wr_en_b = 1; wr_addr_b = 2'd1; wr_data_b = 8'hAA;
    tick();
    @(negedge clk);
    wr_addr_a = 2'd2; wr_addr_b = 2'd3;
    tick();
    @(negedge clk);
    wr_en_a = 0; wr_en_b = 0;
    #1 check_eq("fill_aa", reg_flat, 32'hAAAAAAAA);
    clear_req = 1;
    tick();
    @(negedge clk);
    clear_req = 0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_clear_busy", busy, 0);
    check_eq("rst_mid_clear_flat", reg_flat, 0);
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    #1 rst = 1'b0;
    @(negedge clk);
    wr_en_a = 1; wr_addr_a = 2'd2; wr_data_a = 8'h5A; rd_addr2 = 2'd2;
    #1 check_eq("post_rst_before_edge", rd_data2, 8'h00);
    mdl[2] = 8'h5A;
    sb_push("post_rst_write", 8'h5A);
    tick();
    sb_check(rd_data2);
    check_eq("post_rst_busy", busy, 0);
    @(negedge clk);
    wr_en_a = 0;

    // Wide build: bypass, B priority, zero register
    wr_en_a_z = 1; wr_addr_a_z = 3'd5; wr_data_a_z = 16'hBEEF; rd_addr1_z = 3'd5;
    #1 check_eq("z_bypass_same_cycle", rd_data1_z, 16'hBEEF);
    sb_push("z_stored_r5", 16'hBEEF);
    tick();
    sb_check(rd_data1_z);

    @(negedge clk);
    wr_addr_a_z = 3'd6; wr_data_a_z = 16'h1111;
    wr_en_b_z = 1; wr_addr_b_z = 3'd6; wr_data_b_z = 16'h2222;
    rd_addr2_z = 3'd6;
    #1 check_eq("z_bypass_b_prio", rd_data2_z, 16'h2222);
    sb_push("z_stored_r6", 16'h2222);
    tick();
    sb_check(rd_data2_z);

    @(negedge clk);
    wr_en_b_z = 0;
    wr_addr_a_z = 3'd0; wr_data_a_z = 16'h1234; rd_addr1_z = 3'd0;
    #1 check_eq("z_r0_no_bypass", rd_data1_z, 16'h0000);
    tick();
    check_eq("z_r0_read", rd_data1_z, 16'h0000);
    check_eq("z_r0_flat", reg_flat_z[15:0], 16'h0000);

    // No bypass while the wide build is clearing
    @(negedge clk);
    wr_en_a_z = 0; clear_req_z = 1;
    tick();
    @(negedge clk);
    clear_req_z = 0;
    wr_en_a_z = 1; wr_addr_a_z = 3'd5; wr_data_a_z = 16'h7777; rd_addr1_z = 3'd5;
    #1 check_eq("z_no_bypass_busy", rd_data1_z, 16'hBEEF);
    wr_en_a_z = 0;
    repeat (8) tick();
    check_eq("z_clear_done_busy", busy_z, 0);
    check_eq("z_clear_flat_lo", reg_flat_z[63:0], 0);
    check_eq("z_clear_flat_hi", reg_flat_z[127:64], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
